// File: rtl/axi_wr_router.sv
// axi_wr_router: write-channel router for the 1-master / 2-slave AXI interconnect.
// Accepts one AW burst at a time. It latches the slave select from addr_decoder,
// forwards AW and then the W beats to the chosen slave, and returns that slave's
// B response to the master.
// Optional feature macro: AXI_WR_LEN_CHECK_EN. When it is defined, a beat counter
// is compared against awlen, and a length mismatch forces the response to SLVERR.
module axi_wr_router #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    // master AW
    input  logic [ADDR_W-1:0]   i_m_awaddr,
    input  logic [7:0]          i_m_awlen,
    input  logic                i_m_awvalid,
    output logic                o_m_awready,
    // master W
    input  logic [DATA_W-1:0]   i_m_wdata,
    input  logic [DATA_W/8-1:0] i_m_wstrb,
    input  logic                i_m_wlast,
    input  logic                i_m_wvalid,
    output logic                o_m_wready,
    // master B
    output logic [1:0]          o_m_bresp,
    output logic                o_m_bvalid,
    input  logic                i_m_bready,
    // decoder
    output logic [ADDR_W-1:0]   o_dec_wr_addr,
    input  logic                i_dec_s1_sel,
    input  logic                i_dec_s2_sel,
    input  logic [ADDR_W-1:0]   i_dec_s1_addr,
    input  logic [ADDR_W-1:0]   i_dec_s2_addr,
    // slave AW
    output logic [ADDR_W-1:0]   o_s1_awaddr,
    output logic [ADDR_W-1:0]   o_s2_awaddr,
    output logic [7:0]          o_s_awlen,
    output logic                o_s1_awvalid,
    output logic                o_s2_awvalid,
    input  logic                i_s1_awready,
    input  logic                i_s2_awready,
    // slave W
    output logic [DATA_W-1:0]   o_s_wdata,
    output logic [DATA_W/8-1:0] o_s_wstrb,
    output logic                o_s_wlast,
    output logic                o_s1_wvalid,
    output logic                o_s2_wvalid,
    input  logic                i_s1_wready,
    input  logic                i_s2_wready,
    // slave B
    input  logic [1:0]          i_s1_bresp,
    input  logic [1:0]          i_s2_bresp,
    input  logic                i_s1_bvalid,
    input  logic                i_s2_bvalid,
    output logic                o_s1_bready,
    output logic                o_s2_bready
);

    typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_t;

    state_t            state;
    logic              awready_q;
    logic              s1_awvalid_q;
    logic              s2_awvalid_q;
    logic              sel1_q;
    logic              sel2_q;
    logic [7:0]        len_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic [ADDR_W-1:0] s2_addr_q;
    logic              dec_err;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic              len_err;

    // A select of neither slave, or of both slaves, is a decode error.
    assign dec_err = (sel1_q == sel2_q);
    assign aw_hs   = i_m_awvalid && awready_q;
    assign w_hs    = (state == ST_W) && i_m_wvalid && o_m_wready;
    assign b_hs    = (state == ST_B) && o_m_bvalid && i_m_bready;

    assign o_dec_wr_addr = i_m_awaddr;
    assign o_m_awready   = awready_q;
    assign o_s1_awaddr   = s1_addr_q;
    assign o_s2_awaddr   = s2_addr_q;
    assign o_s_awlen     = len_q;
    assign o_s1_awvalid  = s1_awvalid_q;
    assign o_s2_awvalid  = s2_awvalid_q;
    assign o_s_wdata     = i_m_wdata;
    assign o_s_wstrb     = i_m_wstrb;
    assign o_s_wlast     = i_m_wlast;

    // Transaction sequencing and the registered AW-side handshake outputs.
    // awready is held low for the first cycle after reset, so that every
    // valid/ready output reads 0 while reset is asserted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            awready_q    <= 1'b0;
            s1_awvalid_q <= 1'b0;
            s2_awvalid_q <= 1'b0;
            sel1_q       <= 1'b0;
            sel2_q       <= 1'b0;
            len_q        <= '0;
            s1_addr_q    <= '0;
            s2_addr_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (aw_hs) begin
                        awready_q <= 1'b0;
                        len_q     <= i_m_awlen;
                        sel1_q    <= i_dec_s1_sel;
                        sel2_q    <= i_dec_s2_sel;
                        s1_addr_q <= i_dec_s1_addr;
                        s2_addr_q <= i_dec_s2_addr;
                        if (i_dec_s1_sel != i_dec_s2_sel) begin
                            s1_awvalid_q <= i_dec_s1_sel;
                            s2_awvalid_q <= i_dec_s2_sel;
                            state        <= ST_AW;
                        end else begin
                            state <= ST_W;
                        end
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                ST_AW: begin
                    if ((s1_awvalid_q && i_s1_awready) || (s2_awvalid_q && i_s2_awready)) begin
                        s1_awvalid_q <= 1'b0;
                        s2_awvalid_q <= 1'b0;
                        state        <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_hs && i_m_wlast) state <= ST_B;
                end
                ST_B: begin
                    if (b_hs) begin
                        state     <= ST_IDLE;
                        awready_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef AXI_WR_LEN_CHECK_EN
    logic [7:0] beat_cnt;
    logic       len_err_q;

    // Count the accepted beats and flag a burst whose wlast arrives early or late.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beat_cnt  <= '0;
            len_err_q <= 1'b0;
        end else if (aw_hs) begin
            beat_cnt  <= '0;
            len_err_q <= 1'b0;
        end else if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (i_m_wlast != (beat_cnt == len_q)) len_err_q <= 1'b1;
        end
    end
    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

    // W and B paths are combinational pass-throughs gated by state and the latched select.
    always_comb begin
        o_m_wready  = 1'b0;
        o_s1_wvalid = 1'b0;
        o_s2_wvalid = 1'b0;
        o_m_bvalid  = 1'b0;
        o_m_bresp   = 2'b00;
        o_s1_bready = 1'b0;
        o_s2_bready = 1'b0;
        case (state)
            ST_W: begin
                if (dec_err) begin
                    o_m_wready = 1'b1;
                end else if (sel1_q) begin
                    o_s1_wvalid = i_m_wvalid;
                    o_m_wready  = i_s1_wready;
                end else begin
                    o_s2_wvalid = i_m_wvalid;
                    o_m_wready  = i_s2_wready;
                end
            end
            ST_B: begin
                if (dec_err) begin
                    o_m_bvalid = 1'b1;
                    o_m_bresp  = 2'b11;
                end else begin
                    if (sel1_q) begin
                        o_m_bvalid  = i_s1_bvalid;
                        o_m_bresp   = i_s1_bresp;
                        o_s1_bready = i_m_bready;
                    end else begin
                        o_m_bvalid  = i_s2_bvalid;
                        o_m_bresp   = i_s2_bresp;
                        o_s2_bready = i_m_bready;
                    end
                    if (len_err) o_m_bresp = 2'b10;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_wr_router.sv
// tb_axi_wr_router: directed, table-driven bench for axi_wr_router.
// It models addr_decoder with S1_WIDTH=50. The bench drives inputs on the falling
// clock edge and checks the outputs 1 ns later.
module tb_axi_wr_router;

    localparam int AW = 64;
    localparam int DW = 32;

    logic          clk, rst_n;
    logic [AW-1:0] m_awaddr;
    logic [7:0]    m_awlen;
    logic          m_awvalid, m_awready;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_wstrb;
    logic          m_wlast, m_wvalid, m_wready;
    logic [1:0]    m_bresp;
    logic          m_bvalid, m_bready;
    logic [AW-1:0] dec_wr_addr, dec_s1_addr, dec_s2_addr;
    logic          dec_s1_sel, dec_s2_sel;
    logic [AW-1:0] s1_awaddr, s2_awaddr;
    logic [7:0]    s_awlen;
    logic          s1_awvalid, s2_awvalid, s1_awready, s2_awready;
    logic [DW-1:0] s_wdata;
    logic [3:0]    s_wstrb;
    logic          s_wlast, s1_wvalid, s2_wvalid, s1_wready, s2_wready;
    logic [1:0]    s1_bresp, s2_bresp;
    logic          s1_bvalid, s2_bvalid, s1_bready, s2_bready;
    logic          force_err;

    int total = 0;
    int bad   = 0;

    axi_wr_router #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_m_awaddr(m_awaddr), .i_m_awlen(m_awlen), .i_m_awvalid(m_awvalid), .o_m_awready(m_awready),
        .i_m_wdata(m_wdata), .i_m_wstrb(m_wstrb), .i_m_wlast(m_wlast), .i_m_wvalid(m_wvalid),
        .o_m_wready(m_wready),
        .o_m_bresp(m_bresp), .o_m_bvalid(m_bvalid), .i_m_bready(m_bready),
        .o_dec_wr_addr(dec_wr_addr), .i_dec_s1_sel(dec_s1_sel), .i_dec_s2_sel(dec_s2_sel),
        .i_dec_s1_addr(dec_s1_addr), .i_dec_s2_addr(dec_s2_addr),
        .o_s1_awaddr(s1_awaddr), .o_s2_awaddr(s2_awaddr), .o_s_awlen(s_awlen),
        .o_s1_awvalid(s1_awvalid), .o_s2_awvalid(s2_awvalid),
        .i_s1_awready(s1_awready), .i_s2_awready(s2_awready),
        .o_s_wdata(s_wdata), .o_s_wstrb(s_wstrb), .o_s_wlast(s_wlast),
        .o_s1_wvalid(s1_wvalid), .o_s2_wvalid(s2_wvalid),
        .i_s1_wready(s1_wready), .i_s2_wready(s2_wready),
        .i_s1_bresp(s1_bresp), .i_s2_bresp(s2_bresp),
        .i_s1_bvalid(s1_bvalid), .i_s2_bvalid(s2_bvalid),
        .o_s1_bready(s1_bready), .o_s2_bready(s2_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // addr_decoder stand-in: addresses below 50 go to slave 1, the rest to slave 2 (rebased)
    always_comb begin
        dec_s1_sel  = (dec_wr_addr < 64'd50);
        dec_s2_sel  = !dec_s1_sel;
        dec_s1_addr = dec_wr_addr;
        dec_s2_addr = dec_wr_addr - 64'd50;
        if (force_err) begin
            dec_s1_sel = 1'b0;
            dec_s2_sel = 1'b0;
        end
    end

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        int          nbeats;
        logic [1:0]  sbresp;
        int          awdly;
        int          slv;     // 0 = decode error
        logic [63:0] saddr;
        logic [1:0]  ebresp;
        logic        ferr;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_inputs();
        m_awaddr = '0; m_awlen = '0; m_awvalid = 1'b0;
        m_wdata = '0; m_wstrb = '0; m_wlast = 1'b0; m_wvalid = 1'b0; m_bready = 1'b0;
        s1_awready = 1'b0; s2_awready = 1'b0; s1_wready = 1'b0; s2_wready = 1'b0;
        s1_bresp = 2'b00; s2_bresp = 2'b00; s1_bvalid = 1'b0; s2_bvalid = 1'b0;
        force_err = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        logic [31:0] d;
        // AW offered from the master
        @(negedge clk);
        m_awaddr = v.addr; m_awlen = v.len; m_awvalid = 1'b1; force_err = v.ferr;
        #1;
        chk("awready_idle", m_awready, 1'b1);
        chk("dec_addr", dec_wr_addr, v.addr);
        @(negedge clk);
        m_awvalid = 1'b0;
        m_wvalid = 1'b1; m_wdata = 32'hDEAD_0000; m_wlast = 1'b0;
        if (v.slv != 0) begin
            for (int c = 0; c < v.awdly; c++) begin
                #1;
                chk("aw_stall_valid", (v.slv == 1) ? s1_awvalid : s2_awvalid, 1'b1);
                chk("aw_stall_wready", m_wready, 1'b0);
                @(negedge clk);
            end
            if (v.slv == 1) s1_awready = 1'b1; else s2_awready = 1'b1;
            #1;
            chk("aw_valid_sel", (v.slv == 1) ? s1_awvalid : s2_awvalid, 1'b1);
            chk("aw_valid_other", (v.slv == 1) ? s2_awvalid : s1_awvalid, 1'b0);
            chk("aw_addr", (v.slv == 1) ? s1_awaddr : s2_awaddr, v.saddr);
            chk("aw_len", s_awlen, v.len);
            chk("aw_wready_low", m_wready, 1'b0);
            chk("awready_busy", m_awready, 1'b0);
            @(negedge clk);
            s1_awready = 1'b0; s2_awready = 1'b0;
        end else begin
            #1;
            chk("err_no_awvalid", {s1_awvalid, s2_awvalid}, 2'b00);
        end
        // W beats
        for (int b = 0; b < v.nbeats; b++) begin
            d = 32'hC0DE_0000 + b;
            m_wdata = d; m_wstrb = 4'hF ^ b[3:0]; m_wlast = (b == v.nbeats - 1);
            m_wvalid = 1'b1;
            s1_wready = (v.slv == 1); s2_wready = (v.slv == 2);
            #1;
            chk("w_mready", m_wready, 1'b1);
            chk("w_s1_valid", s1_wvalid, v.slv == 1);
            chk("w_s2_valid", s2_wvalid, v.slv == 2);
            chk("w_data", s_wdata, d);
            chk("w_strb", s_wstrb, 4'hF ^ b[3:0]);
            chk("w_last", s_wlast, b == v.nbeats - 1);
            @(negedge clk);
        end
        // B: hold master bready low one cycle, then complete
        m_wvalid = 1'b0; m_wlast = 1'b0; s1_wready = 1'b0; s2_wready = 1'b0;
        s1_bvalid = (v.slv == 1); s2_bvalid = (v.slv == 2);
        s1_bresp = v.sbresp; s2_bresp = v.sbresp;
        m_bready = 1'b0;
        #1;
        chk("b_valid_wait", m_bvalid, 1'b1);
        chk("b_bready_wait", {s1_bready, s2_bready}, 2'b00);
        @(negedge clk);
        m_bready = 1'b1;
        #1;
        chk("b_valid", m_bvalid, 1'b1);
        chk("b_resp", m_bresp, v.ebresp);
        chk("b_s1_bready", s1_bready, v.slv == 1);
        chk("b_s2_bready", s2_bready, v.slv == 2);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("b_done_bvalid", m_bvalid, 1'b0);
        chk("b_done_awready", m_awready, 1'b1);
    endtask

    vec_t tv[7];
    logic [1:0] len_bad_00, len_bad_01;

    initial begin
`ifdef AXI_WR_LEN_CHECK_EN
        len_bad_00 = 2'b10; len_bad_01 = 2'b10;
`else
        len_bad_00 = 2'b00; len_bad_01 = 2'b01;
`endif
        //        addr len nb resp dly slv saddr ebresp ferr
        tv[0] = '{64'd10, 8'd3, 4, 2'b00, 0, 1, 64'd10, 2'b00, 1'b0};
        tv[1] = '{64'd75, 8'd0, 1, 2'b01, 0, 2, 64'd25, 2'b01, 1'b0};
        tv[2] = '{64'd20, 8'd1, 2, 2'b00, 5, 1, 64'd20, 2'b00, 1'b0};
        tv[3] = '{64'd30, 8'd1, 2, 2'b00, 0, 0, 64'd0,  2'b11, 1'b1};
        tv[4] = '{64'd5,  8'd3, 2, 2'b01, 0, 1, 64'd5,  len_bad_01, 1'b0};
        tv[5] = '{64'd99, 8'd2, 3, 2'b10, 2, 2, 64'd49, 2'b10, 1'b0};
        tv[6] = '{64'd55, 8'd0, 2, 2'b00, 0, 2, 64'd5,  len_bad_00, 1'b0};

        clear_inputs();
        rst_n = 1'b0;
        #2;
        chk("rst_awready", m_awready, 1'b0);
        chk("rst_valids", {s1_awvalid, s2_awvalid, s1_wvalid, s2_wvalid, m_bvalid}, 5'b0);
        chk("rst_bresp", m_bresp, 2'b00);
        chk("rst_awlen", s_awlen, 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_txn(tv[i]);

        // Reset asserted during beat 2 of a 4-beat burst to slave 1
        @(negedge clk);
        m_awaddr = 64'd10; m_awlen = 8'd3; m_awvalid = 1'b1;
        @(negedge clk);
        m_awvalid = 1'b0; s1_awready = 1'b1;
        @(negedge clk);
        s1_awready = 1'b0; m_wvalid = 1'b1; m_wlast = 1'b0; s1_wready = 1'b1;
        #1;
        chk("rst_beat1_wready", m_wready, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_wvalid", {s1_wvalid, s2_wvalid}, 2'b00);
        chk("midrst_wready", m_wready, 1'b0);
        chk("midrst_aw", {m_awready, s1_awvalid, s2_awvalid}, 3'b000);
        chk("midrst_bvalid", m_bvalid, 1'b0);
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b1;
        run_txn('{64'd60, 8'd0, 1, 2'b00, 0, 2, 64'd10, 2'b00, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
